dot_pipe: RTL and testbench
===========================

Name: dot_pipe

Overview:
Pipelined, parametrised N-element fixed-point dot product. It is the successor to the single-shot 3-element dot unit.
- Accepts one vector pair per cycle from an upstream FIFO (empty/rd_en) and pushes results to a downstream FIFO (full/wr_en).
- Sits in the fifo_math datapath between vector-producing stages and the ray/plane intersection math.
- Adds generic width, element count, a 3-stage pipeline with full-throughput backpressure, and optional saturation.

Parameters:
DATA_WIDTH, 32, signed element and result width
Q_BITS, 10, fractional bits of the fixed-point format; each product is arithmetically shifted right by Q_BITS
N_ELEM, 3, vector length (>=1)

Ports:
clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous, active-low reset
x  in  DATA_WIDTH x N_ELEM  signed vector operand, unpacked [N_ELEM-1:0]
y  in  DATA_WIDTH x N_ELEM  signed vector operand, unpacked [N_ELEM-1:0]
in_empty  in  1  upstream FIFO empty
in_rd_en  out  1  pop upstream; x/y are consumed this cycle
out  out  DATA_WIDTH  signed result, valid while out_wr_en=1
out_full  in  1  downstream FIFO full
out_wr_en  out  1  push out to downstream
overflow  out  1  sticky: some result exceeded the DATA_WIDTH range

Behaviour:
- Reset (reset_n=0, asynchronous): all stage valid bits=0, all data regs=0, out=0, overflow=0. in_rd_en=0 and out_wr_en=0 while reset_n=0. Reset mid-stream discards in-flight items without emitting them.
- Stages:
  - S1 register: N_ELEM products, 2*DATA_WIDTH signed each.
  - S2 register: sum of (product >>> Q_BITS) terms. ACC_W = 2*DATA_WIDTH + clog2(N_ELEM) bits. Shift is arithmetic, so results floor toward minus infinity.
  - S3 register: sum reduced to DATA_WIDTH and held as out, with valid bit v3.
- Handshake (combinational):
  - advance = !v3 | !out_full
  - out_wr_en = v3 & !out_full
  - in_rd_en = advance & !in_empty
- When advance=1, every stage shifts forward and S1 captures a new item iff in_rd_en. When advance=0, all stages hold.
- Bubbles do not compact: v1/v2 may be 0 while the pipeline is stalled.
- Latency: item popped in cycle T gives out_wr_en in cycle T+3 when out_full=0. Throughput is 1 item/cycle. Order is preserved; no loss or duplication under any out_full pattern.
- out holds its last value when v3=0.
- Simultaneous pop and push in the same cycle is legal and required for full throughput.
- out_full toggling every cycle gives exactly one push per cycle out_full=0 (given supply).
- Reduction: wrap mode takes the low DATA_WIDTH bits of the sum. overflow sets on push of an item whose sum lies outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], and clears only on reset.

Optional Feature:
DOT_PIPE_SATURATE_EN
- Defined: an out-of-range sum clamps to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1). overflow is still set.
- Undefined: wrap (truncate) as above. Port list is identical in both builds.

Decomposition:
- Package dot_pkg: function acc_width(DATA_WIDTH, N_ELEM), and localparam MIN/MAX constant helpers for the range check.
- One sub-module, dot_reduce: ACC_W -> DATA_WIDTH range check plus saturate/wrap, combinational, used before S3. The macro affects only this sub-module.

Test Plan:
- x=(1024,2048,3072), y=(1024,1024,1024), out_full=0 -> pop at T, out_wr_en at T+3, out=6144, overflow=0.
- x=(-1,0,0), y=(1,0,0) -> out=-1 (floor); x=(-1536,0,0), y=(1024,0,0) -> out=-1536.
- 8 back-to-back vectors (x0=k*1024, y0=1024, others 0), out_full=0 -> 8 consecutive pushes out=0..7168, in_rd_en high 8 cycles.
- Same 8 vectors with out_full high for cycles 4-8 -> in_rd_en drops while stalled, results in order, none lost or duplicated.
- All elements 0x7FFFFFFF (DATA_WIDTH=32) -> with macro out=0x7FFFFFFF, without out=0xFF400000. overflow=1 and sticky across following in-range items.
- reset_n low with 3 items in flight -> out=0, out_wr_en=0, overflow=0 immediately. After release, no stale pushes; next item emerges 3 cycles after its pop.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared helpers for the dot_pipe datapath: accumulator sizing and the
// signed range limits used when reducing the wide sum to DATA_WIDTH.
package dot_pkg;

  localparam int unsigned MAX_ACC_W = 256;

  typedef logic signed [MAX_ACC_W-1:0] wide_t;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
    return 2 * dw + $clog2(n);
  endfunction

  // Largest positive value representable in dw signed bits, sign-extended to wide_t.
  function automatic wide_t max_of(input int unsigned dw);
    wide_t r;
    r = '0;
    r[dw-1] = 1'b1;
    return r - wide_t'(1);
  endfunction

  function automatic wide_t min_of(input int unsigned dw);
    return ~max_of(dw);
  endfunction

endpackage

// File: rtl/dot_pipe_if.sv
// Upstream-FIFO / downstream-FIFO handshake bundle for dot_pipe.
// slave is the pipe side; master is the surrounding datapath.
interface dot_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_ELEM     = 3
);

  logic signed [DATA_WIDTH-1:0] x [N_ELEM-1:0];
  logic signed [DATA_WIDTH-1:0] y [N_ELEM-1:0];
  logic                         in_empty;
  logic                         in_rd_en;
  logic signed [DATA_WIDTH-1:0] out;
  logic                         out_full;
  logic                         out_wr_en;
  logic                         overflow;

  modport master (
    output x, y, in_empty, out_full,
    input  in_rd_en, out, out_wr_en, overflow
  );

  modport slave (
    input  x, y, in_empty, out_full,
    output in_rd_en, out, out_wr_en, overflow
  );

endinterface

// File: rtl/dot_reduce.sv
// Combinational ACC_W -> DATA_WIDTH reduction with out-of-range detection.
// DOT_PIPE_SATURATE_EN selects clamping; otherwise the low bits are kept (wrap).
module dot_reduce
  import dot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_W      = 66
) (
  input  logic signed [ACC_W-1:0]      sum,
  output logic signed [DATA_WIDTH-1:0] res,
  output logic                         ovf
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(max_of(DATA_WIDTH));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(min_of(DATA_WIDTH));

  logic too_high;
  logic too_low;

  always_comb begin
    too_high = (sum > MAX_V);
    too_low  = (sum < MIN_V);
    ovf      = too_high | too_low;
`ifdef DOT_PIPE_SATURATE_EN
    if (too_high) begin
      res = MAX_V[DATA_WIDTH-1:0];
    end else if (too_low) begin
      res = MIN_V[DATA_WIDTH-1:0];
    end else begin
      res = sum[DATA_WIDTH-1:0];
    end
`else
    res = sum[DATA_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/dot_pipe.sv
// 3-stage pipelined N-element fixed-point dot product between two FIFOs.
// Saturation vs. wrap is chosen by DOT_PIPE_SATURATE_EN inside dot_reduce.
module dot_pipe
  import dot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned Q_BITS     = 10,
  parameter int unsigned N_ELEM     = 3
) (
  input logic       clock,
  input logic       reset_n,
  dot_pipe_if.slave io
);

  localparam int unsigned PW    = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W = acc_width(DATA_WIDTH, N_ELEM);

  logic signed [PW-1:0]         prod_q [N_ELEM-1:0];
  logic signed [PW-1:0]         prod_d [N_ELEM-1:0];
  logic signed [ACC_W-1:0]      sum_q, sum_d, acc;
  logic signed [DATA_WIDTH-1:0] out_q, out_d, red;
  logic                         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                         ovf3_q, ovf3_d, red_ovf;
  logic                         overflow_q, overflow_d;
  logic                         advance, rd_en, wr_en;

  // Strobes are gated by reset_n so neither FIFO is touched while reset is held.
  always_comb begin
    advance = !v3_q || !io.out_full;
    wr_en   = v3_q && !io.out_full && reset_n;
    rd_en   = advance && !io.in_empty && reset_n;
  end

  assign io.in_rd_en  = rd_en;
  assign io.out_wr_en = wr_en;
  assign io.out       = out_q;
  assign io.overflow  = overflow_q;

  dot_reduce #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_W     (ACC_W)
  ) u_reduce (
    .sum(sum_q),
    .res(red),
    .ovf(red_ovf)
  );

  always_comb begin
    v1_d = advance ? rd_en : v1_q;
    v2_d = advance ? v1_q  : v2_q;
    v3_d = advance ? v2_q  : v3_q;

    for (int unsigned i = 0; i < N_ELEM; i++) begin
      prod_d[i] = rd_en ? (PW'(io.x[i]) * PW'(io.y[i])) : prod_q[i];
    end

    // Each product is floored to Q format before summing, not the final sum.
    acc = '0;
    for (int unsigned i = 0; i < N_ELEM; i++) begin
      acc = acc + ACC_W'(prod_q[i] >>> Q_BITS);
    end
    sum_d = (advance && v1_q) ? acc : sum_q;

    out_d  = (advance && v2_q) ? red     : out_q;
    ovf3_d = (advance && v2_q) ? red_ovf : ovf3_q;

    overflow_d = overflow_q | (wr_en & ovf3_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prod_q     <= '{default: '0};
      sum_q      <= '0;
      out_q      <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      ovf3_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      sum_q      <= sum_d;
      out_q      <= out_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      ovf3_q     <= ovf3_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_dot_pipe.sv
// Directed self-checking bench for dot_pipe (DATA_WIDTH=32, Q_BITS=10, N_ELEM=3).
// Expected overflow result follows DOT_PIPE_SATURATE_EN if defined for the build.
module tb_dot_pipe;

  logic clock;
  logic reset_n;

  int n_vec = 0;
  int n_err = 0;
  int pushes = 0;
  int exp_q[$];

`ifdef DOT_PIPE_SATURATE_EN
  localparam int EXP_OVF = 32'h7FFFFFFF;
`else
  localparam int EXP_OVF = 32'hFF400000;
`endif

  dot_pipe_if #(.DATA_WIDTH(32), .N_ELEM(3)) io ();

  dot_pipe #(
    .DATA_WIDTH(32),
    .Q_BITS    (10),
    .N_ELEM    (3)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .io     (io)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_xy(input int x0, input int x1, input int x2,
                        input int y0, input int y1, input int y2);
    io.x[0] = x0; io.x[1] = x1; io.x[2] = x2;
    io.y[0] = y0; io.y[1] = y1; io.y[2] = y2;
  endtask

  // One cycle starting just after a falling edge: drive, check strobes and any push.
  task automatic step(input bit empty, input bit full, input bit exp_rd,
                      input bit exp_wr, input int val);
    io.in_empty = empty;
    io.out_full = full;
    #1;
    chk("in_rd_en", 32'(io.in_rd_en), 32'(exp_rd));
    chk("out_wr_en", 32'(io.out_wr_en), 32'(exp_wr));
    if (exp_rd) exp_q.push_back(val);
    if (io.out_wr_en) begin
      pushes++;
      if (exp_q.size() == 0) chk("stray_push", 32'(io.out_wr_en), 32'd0);
      else chk("out", io.out, exp_q.pop_front());
    end
    @(negedge clock);
  endtask

  initial begin
    reset_n     = 1'b0;
    io.in_empty = 1'b0;
    io.out_full = 1'b0;
    set_xy(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    #1;
    chk("rst_in_rd_en", 32'(io.in_rd_en), 32'd0);
    chk("rst_out_wr_en", 32'(io.out_wr_en), 32'd0);
    chk("rst_out", io.out, 32'd0);
    chk("rst_overflow", 32'(io.overflow), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic product sum and 3-cycle latency
    set_xy(1024, 2048, 3072, 1024, 1024, 1024);
    step(0, 0, 1, 0, 6144);
    set_xy(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("out_hold", io.out, 32'd6144);
    chk("ovf_in_range", 32'(io.overflow), 32'd0);

    // Floor toward minus infinity
    set_xy(-1, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, -1);
    set_xy(-1536, 0, 0, 1024, 0, 0);
    step(0, 0, 1, 0, -1536);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);

    // 8 back-to-back items, no backpressure
    pushes = 0;
    for (int k = 0; k < 8; k++) begin
      set_xy(k * 1024, 0, 0, 1024, 0, 0);
      step(0, 0, 1, (k >= 3), k * 1024);
    end
    for (int c = 0; c < 3; c++) step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("b2b_pushes", 32'(pushes), 32'd8);

    // Same 8 items with out_full high in cycles 4..8
    begin
      int  k;
      bit  full, empty;
      k = 0;
      pushes = 0;
      for (int c = 1; c <= 17; c++) begin
        full  = (c >= 4) && (c <= 8);
        empty = (k >= 8);
        set_xy(k * 1024, 0, 0, 1024, 0, 0);
        step(empty, full, !empty && !full, (c >= 9) && (c <= 16), k * 1024);
        if (!empty && !full) k++;
      end
      chk("stall_pushes", 32'(pushes), 32'd8);
      chk("stall_leftover", 32'(exp_q.size()), 32'd0);
    end

    // Out-of-range sum, then sticky overflow across an in-range item
    set_xy(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    step(0, 0, 1, 0, EXP_OVF);
    set_xy(1024, 0, 0, 1024, 0, 0);
    step(0, 0, 1, 0, 1024);
    step(1, 0, 0, 0, 0);
    chk("ovf_before_push", 32'(io.overflow), 32'd0);
    step(1, 0, 0, 1, 0);
    chk("ovf_set", 32'(io.overflow), 32'd1);
    step(1, 0, 0, 1, 0);
    chk("ovf_sticky", 32'(io.overflow), 32'd1);

    // Reset with 3 items in flight
    set_xy(1024, 0, 0, 1024, 0, 0);
    step(0, 0, 1, 0, 1024);
    set_xy(2048, 0, 0, 1024, 0, 0);
    step(0, 0, 1, 0, 2048);
    set_xy(3072, 0, 0, 1024, 0, 0);
    step(0, 0, 1, 0, 3072);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out", io.out, 32'd0);
    chk("mid_rst_out_wr_en", 32'(io.out_wr_en), 32'd0);
    chk("mid_rst_overflow", 32'(io.overflow), 32'd0);
    chk("mid_rst_in_rd_en", 32'(io.in_rd_en), 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    set_xy(5120, 0, 0, 1024, 0, 0);
    step(0, 0, 1, 0, 5120);
    set_xy(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("post_rst_overflow", 32'(io.overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
